seq_alu_param: RTL and testbench

- Parametrised multi-cycle sequential ALU with FSM control. Next generation of the team's 4-bit start/ready ALU.
- Adds configurable WIDTH, a 3-bit opcode, iterative shifts, an optional iterative multiplier, and status flags (carry, zero, overflow, err).
- Sits under the top-level controller, which drives operands and start and waits on ready.

---
 rtl/seq_alu_param.sv | 220 ++++++++++++++++++++++
 tb/tb_seq_alu_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_param.sv
// seq_alu_param: multi-cycle ALU with start/ready handshake and status flags.
// Optional iterative multiplier on opcode 111, enabled by SEQ_ALU_MUL_EN.
module seq_alu_param #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             err,
  output logic             busy,
  output logic             ready
);

  localparam int CW  = SHW + 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             car_q, car_d;
  logic             zer_q, zer_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] p_q, p_d, p_n;
  logic [WIDTH:0]     msum;
`endif

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] shl_w;
  logic [WIDTH-1:0] shr_w;
  logic [WIDTH-1:0] f_res;
  logic             f_car;
  logic             f_ovf;
  logic             f_err;
  logic             k0;

  // Per-step datapath terms and the value written on the final step
  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    shl_w = {w_q[WIDTH-2:0], 1'b0};
    shr_w = {1'b0, w_q[WIDTH-1:1]};
    k0    = (b_q[SHW-1:0] == '0);
`ifdef SEQ_ALU_MUL_EN
    msum  = {1'b0, p_q[2*WIDTH-1:WIDTH]}
          + (p_q[0] ? {1'b0, a_q} : '0);
    p_n   = {msum, p_q[WIDTH-1:1]};
`endif
    f_res = '0;
    f_car = 1'b0;
    f_ovf = 1'b0;
    f_err = 1'b0;
    unique case (sel_q)
      OP_ADD: begin
        f_res = sum[WIDTH-1:0];
        f_car = sum[WIDTH];
        f_ovf = (a_q[MSB] == b_q[MSB])
             && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        f_res = diff[WIDTH-1:0];
        f_car = diff[WIDTH];
        f_ovf = (a_q[MSB] != b_q[MSB])
             && (diff[MSB] != a_q[MSB]);
      end
      OP_AND: f_res = a_q & b_q;
      OP_XOR: f_res = a_q ^ b_q;
      OP_OR:  f_res = a_q | b_q;
      OP_SHL: begin
        f_res = k0 ? w_q : shl_w;
        f_car = !k0 && w_q[MSB];
      end
      OP_SHR: begin
        f_res = k0 ? w_q : shr_w;
        f_car = !k0 && w_q[0];
      end
      OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
        f_res = p_n[WIDTH-1:0];
        f_car = |p_n[2*WIDTH-1:WIDTH];
`else
        f_err = 1'b1;
`endif
      end
    endcase
  end

  // Control FSM: capture on accept, step in EXEC, commit on last step
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    car_d   = car_q;
    zer_d   = zer_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    rdy_d   = rdy_q;
`ifdef SEQ_ALU_MUL_EN
    p_d     = p_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sel_d   = sel;
          w_d     = a;
          rdy_d   = 1'b0;
          state_d = EXEC;
          cnt_d   = CW'(1);
          if ((sel == OP_SHL || sel == OP_SHR)
              && b[SHW-1:0] != '0)
            cnt_d = CW'(b[SHW-1:0]);
`ifdef SEQ_ALU_MUL_EN
          p_d = {{WIDTH{1'b0}}, b};
          if (sel == OP_MUL)
            cnt_d = CW'(WIDTH);
`endif
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (sel_q == OP_SHL)
          w_d = shl_w;
        else if (sel_q == OP_SHR)
          w_d = shr_w;
`ifdef SEQ_ALU_MUL_EN
        p_d = p_n;
`endif
        if (cnt_q == CW'(1)) begin
          res_d   = f_res;
          car_d   = f_car;
          zer_d   = (f_res == '0);
          ovf_d   = f_ovf;
          err_d   = f_err;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and output registers, reset has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      car_q   <= 1'b0;
      zer_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      p_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      car_q   <= car_d;
      zer_q   <= zer_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
`ifdef SEQ_ALU_MUL_EN
      p_q     <= p_d;
`endif
    end
  end

  assign result   = res_q;
  assign carry    = car_q;
  assign zero     = zer_q;
  assign overflow = ovf_q;
  assign err      = err_q;
  assign ready    = rdy_q;
  assign busy     = (state_q == EXEC);

endmodule

// File: tb/tb_seq_alu_param.sv
// tb_seq_alu_param: directed vector table plus abort/ignore sequences.
// Expectations follow SEQ_ALU_MUL_EN when it is defined.
module tb_seq_alu_param;
  localparam int W = 8;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] XOR = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] SHL = 3'b101;
  localparam logic [2:0] SHR = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   sel;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         overflow;
  logic         err;
  logic         busy;
  logic         ready;

  int n_chk = 0;
  int n_err = 0;

  seq_alu_param #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .sel(sel),
    .result(result),
    .carry(carry),
    .zero(zero),
    .overflow(overflow),
    .err(err),
    .busy(busy),
    .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s;
    logic [7:0] xa;
    logic [7:0] xb;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
    logic       e;
    int         lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] s,
                     input logic [7:0] xa,
                     input logic [7:0] xb,
                     input logic [7:0] r,
                     input logic c, input logic z,
                     input logic v, input logic e,
                     input int l);
    vec_t t;
    t.s = s; t.xa = xa; t.xb = xb; t.r = r;
    t.c = c; t.z = z; t.v = v; t.e = e;
    t.lat = l;
    vt.push_back(t);
  endtask

  // Called 1 time unit after a rising edge.
  task automatic run_op(input string nm,
                        input logic [2:0] s,
                        input logic [7:0] xa,
                        input logic [7:0] xb,
                        output int cyc,
                        output int bc);
    a = xa; b = xb; sel = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~xa; b = ~xb; sel = ~s;
    chk({nm, "_rdy_drop"}, 32'(ready), 32'd0);
    cyc = 0;
    bc = 0;
    while (!ready && cyc < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc, bc;
    logic [2:0] ls;
    logic [7:0] la, lb, lr;
    int llat;

    rst = 1'b1; start = 1'b0;
    a = '0; b = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    add(ADD, 8'd200, 8'd100, 8'd44, 1, 0, 0, 0, 1);
    add(SUB, 8'd5, 8'd7, 8'hFE, 1, 0, 0, 0, 1);
    add(SUB, 8'h80, 8'h01, 8'h7F, 0, 0, 1, 0, 1);
    add(ADD, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 0, 1);
    add(XOR, 8'hAA, 8'hAA, 8'h00, 0, 1, 0, 0, 1);
    add(AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 1);
    add(OR,  8'hF0, 8'h0F, 8'hFF, 0, 0, 0, 0, 1);
    add(SHL, 8'h81, 8'd3, 8'h08, 0, 0, 0, 0, 3);
    add(SHL, 8'h81, 8'd1, 8'h02, 1, 0, 0, 0, 1);
    add(SHR, 8'h01, 8'd0, 8'h01, 0, 0, 0, 0, 1);
    add(SHR, 8'h03, 8'd2, 8'h00, 1, 1, 0, 0, 2);
    add(SHL, 8'h01, 8'd7, 8'h80, 0, 0, 0, 0, 7);
    add(SHL, 8'h01, 8'h0B, 8'h08, 0, 0, 0, 0, 3);
`ifdef SEQ_ALU_MUL_EN
    add(MUL, 8'd15, 8'd17, 8'hFF, 0, 0, 0, 0, 8);
    add(MUL, 8'd16, 8'd16, 8'h00, 1, 1, 0, 0, 8);
    add(MUL, 8'hFF, 8'hFF, 8'h01, 1, 0, 0, 0, 8);
`else
    add(MUL, 8'd15, 8'd17, 8'h00, 0, 1, 0, 1, 1);
`endif

    for (int i = 0; i < vt.size(); i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      run_op(nm, vt[i].s, vt[i].xa, vt[i].xb, cyc, bc);
      chk({nm, "_lat"}, 32'(cyc), 32'(vt[i].lat));
      chk({nm, "_busy"}, 32'(bc), 32'(vt[i].lat));
      chk({nm, "_res"}, 32'(result), 32'(vt[i].r));
      chk({nm, "_c"}, 32'(carry), 32'(vt[i].c));
      chk({nm, "_z"}, 32'(zero), 32'(vt[i].z));
      chk({nm, "_v"}, 32'(overflow), 32'(vt[i].v));
      chk({nm, "_e"}, 32'(err), 32'(vt[i].e));
    end

`ifdef SEQ_ALU_MUL_EN
    ls = MUL; la = 8'd15; lb = 8'd17;
    lr = 8'hFF; llat = 8;
`else
    ls = SHL; la = 8'h01; lb = 8'd7;
    lr = 8'h80; llat = 7;
`endif

    a = la; b = lb; sel = ls; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    start = 1'b1; a = 8'h03; b = 8'h03; sel = ADD;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    cyc = 2;
    while (!ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ign_lat", 32'(cyc), 32'(llat));
    chk("ign_res", 32'(result), 32'(lr));
    @(posedge clk); #1;
    chk("ign_hold_rdy", 32'(ready), 32'd1);
    chk("ign_hold_busy", 32'(busy), 32'd0);
    chk("ign_hold_res", 32'(result), 32'(lr));

    a = la; b = lb; sel = ls; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre_res", 32'(result), 32'(lr));
    chk("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_res", 32'(result), 32'd0);
    chk("abort_carry", 32'(carry), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle", 32'(ready), 32'd0);
    run_op("post", ADD, 8'd1, 8'd1, cyc, bc);
    chk("post_lat", 32'(cyc), 32'd1);
    chk("post_res", 32'(result), 32'd2);
    chk("post_z", 32'(zero), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
